// File: rtl/stopuhr_core.sv
// Stopwatch core: button synchronisation and debounce, IDLE/RUN/STOP/LAP control,
// 1/100 s prescaler and a four-digit BCD time count with lap capture.
module stopuhr_core #(
    parameter int CLK_DIV    = 500000,
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_startstop,
    input  logic       btn_lapreset,
    output logic [3:0] data0,
    output logic [3:0] data1,
    output logic [3:0] data2,
    output logic [3:0] data3,
    output logic       running,
    output logic       lap_active,
    output logic [1:0] fsm_state
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    // Button index 0 is start/stop, index 1 is lap/reset.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    armed;
    logic [1:0]    press;
    logic [1:0]    fill;
    logic [DW-1:0] deb_cnt [2];

    // A button held through reset is not armed until it has been seen released,
    // so holding it cannot fake a press once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            armed <= '0;
            press <= '0;
            fill  <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_lapreset, btn_startstop};
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (fill[1] && !sync2[i]) begin
                    armed[i] <= 1'b1;
                end
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= sync2[i] & armed[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (r[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   count;
    logic [15:0]   lap;
    logic          counting;
    logic          tick;
    logic          ss_press;
    logic          lr_press;

    always_comb begin
        counting = (state == RUN) || (state == LAP);
        tick     = counting && (presc == PRESC_LAST);
        ss_press = press[0];
        lr_press = press[1] & ~press[0];
    end

    // Count update comes first so a transition in the same cycle can override it
    // (clear on IDLE entry) or sample the pre-increment value (lap capture).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            count      <= '0;
            lap        <= '0;
            data0      <= 4'd0;
            data1      <= 4'd0;
            data2      <= 4'd0;
            data3      <= 4'd0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            if (tick) begin
                presc <= '0;
                count <= bcd_inc(count);
            end else if (counting) begin
                presc <= presc + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_press) begin
                        state <= RUN;
                        presc <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (ss_press) begin
                        state <= STOP;
                    end else if (lr_press) begin
                        state <= LAP;
                        lap   <= count;
                    end
                end
                LAP: begin
                    if (ss_press) begin
                        state <= STOP;
                    end else if (lr_press) begin
                        state <= RUN;
                    end
                end
                STOP: begin
                    if (ss_press) begin
                        state <= RUN;
                    end else if (lr_press) begin
                        state <= IDLE;
                        presc <= '0;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            {data0, data1, data2, data3} <= (state == LAP) ? lap : count;
            running    <= counting;
            lap_active <= (state == LAP);
        end
    end

    assign fsm_state = state;

endmodule
